// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// uart_rx_pkt_ctrl_pkg: frame-parser state encodings, error codes and defaults
// shared by the packet controller and its bench.
package uart_rx_pkt_ctrl_pkg;

  // Parser states; HUNT is the idle / resynchronising state.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  // err_code values reported alongside pkt_err.
  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_FE      = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

  // A LEN byte is legal when it is non-zero and not above the configured maximum.
  function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_gap_timer.sv
// rx_gap_timer: counts clock cycles since the last restart while enabled and
// flags expiry once LIMIT cycles have elapsed. Held at zero while disabled.
module rx_gap_timer #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic clr,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_cnt;

  // Gap counter: cleared by reset, restart or disable; saturates at expiry.
  always_ff @(posedge clk) begin
    if (clr || i_restart || !i_enable) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The edge at which this is high is the LIMIT-th cycle after the restart.
  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: consumes bytes from uart_rx and parses SOF, LEN, payload,
// CSUM frames; payload is streamed on a valid/ready port, completion or abort
// is reported as single-cycle pulses.
// Optional feature: define UART_RX_PKT_CTRL_TIMEOUT_EN to abort frames whose
// inter-byte gap reaches TIMEOUT clock cycles (err_code 00).
//
// Handshake: out_valid/out_data/out_last are held stable while out_valid=1 and
// out_ready=0; a byte transfers on a clock edge where both are high. No new
// byte is consumed from uart_rx while a presented byte is stalled.
module uart_rx_pkt_ctrl
  import uart_rx_pkt_ctrl_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE = DEF_SOF_BYTE,
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [15:0] TIMEOUT  = 16'd26000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] rx_data,
  input  logic       rdrf,
  input  logic       FE,
  output logic       rdrf_clr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  state_t     r_state;
  logic [7:0] r_sum;
  logic [7:0] r_count;

  logic       w_stall;
  logic       w_consume;
  logic       w_expired;
  logic [7:0] w_csum_total;

  assign w_stall      = out_valid & ~out_ready;
  // rdrf is ignored in the rdrf_clr cycle so one byte is never taken twice.
  assign w_consume    = rdrf & ~rdrf_clr & ~w_stall;
  assign w_csum_total = r_sum + rx_data;

`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
  rx_gap_timer #(
    .WIDTH (16),
    .LIMIT (TIMEOUT)
  ) u_gap_timer (
    .clk       (clk),
    .clr       (clr),
    .i_restart (w_consume),
    .i_enable  (r_state != ST_HUNT),
    .o_expired (w_expired)
  );
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign w_expired        = 1'b0;
`endif

  // Frame parser: consumes one byte per consume edge and drives all outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_HUNT;
      r_sum     <= '0;
      r_count   <= '0;
      rdrf_clr  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      rdrf_clr <= w_consume;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (w_consume) begin
        case (r_state)
          ST_HUNT: begin
            if (!FE && rx_data == SOF_BYTE) r_state <= ST_LEN;
          end
          ST_LEN: begin
            if (FE) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_FE;
              r_state  <= ST_HUNT;
            end else if (!len_legal(rx_data, 8'(MAX_LEN))) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
              r_state  <= ST_HUNT;
            end else begin
              r_sum   <= rx_data;
              r_count <= rx_data;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (FE) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_FE;
              r_state  <= ST_HUNT;
            end else begin
              out_data  <= rx_data;
              out_valid <= 1'b1;
              out_last  <= (r_count == 8'd1);
              r_sum     <= w_csum_total;
              r_count   <= r_count - 8'd1;
              if (r_count == 8'd1) r_state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (FE) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_FE;
            end else if (w_csum_total == 8'd0) begin
              pkt_done <= 1'b1;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= ERR_CSUM;
            end
            r_state <= ST_HUNT;
          end
          default: r_state <= ST_HUNT;
        endcase
      end else if (w_expired) begin
        pkt_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
        r_state  <= ST_HUNT;
      end
    end
  end

  assign busy        = (r_state != ST_HUNT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: directed frames through an emulated uart_rx; a
// frame-level model fills expected payload/result queues that a per-cycle
// monitor drains against the DUT.
module tb_uart_rx_pkt_ctrl;
  import uart_rx_pkt_ctrl_pkg::*;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 100;
  localparam logic [7:0] SOF     = 8'hA5;
  // Expected result encoding: {pkt_done, pkt_err, err_code}
  localparam logic [3:0] R_DONE  = 4'b1000;
  localparam logic [3:0] R_TMO   = 4'b0100;
  localparam logic [3:0] R_FE    = 4'b0101;
  localparam logic [3:0] R_LEN   = 4'b0110;
  localparam logic [3:0] R_CSUM  = 4'b0111;

  // ---------------- clock / reset / signals ----------------
  logic       clk       = 1'b0;
  logic       clr       = 1'b1;
  logic [7:0] rx_data   = 8'h00;
  logic       rdrf      = 1'b0;
  logic       fe        = 1'b0;
  logic       out_ready = 1'b1;
  logic       rdrf_clr, out_valid, out_last, pkt_done, pkt_err, busy;
  logic [7:0] out_data;
  logic [1:0] err_code, dbg_state;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .SOF_BYTE (SOF),
    .MAX_LEN  (MAX_LEN),
    .TIMEOUT  (16'(TMO))
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .rx_data     (rx_data),
    .rdrf        (rdrf),
    .FE          (fe),
    .rdrf_clr    (rdrf_clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .pkt_done    (pkt_done),
    .pkt_err     (pkt_err),
    .err_code    (err_code),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {last, data}
  logic [3:0] res_q[$];   // {done, err, code}
  int checks = 0, failures = 0, clr_pulses = 0, done_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 32'({rdrf_clr, out_data, out_valid, out_last, pkt_done, pkt_err, err_code, busy}), 32'd0);
  endtask

  // Frame-level model: walks a byte stream ({fe, byte}) and lists the payload
  // bytes and packet results the controller must produce.
  task automatic model_stream(input logic [8:0] s[$]);
    int i, len;
    logic [7:0] sum;
    bit cut;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != {1'b0, SOF}) begin i++; continue; end
      i++;
      if (i >= s.size()) break;
      if (s[i][8]) begin res_q.push_back(R_FE); i++; continue; end
      len = int'(s[i][7:0]);
      sum = s[i][7:0];
      i++;
      if (len == 0 || len > MAX_LEN) begin res_q.push_back(R_LEN); continue; end
      cut = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (i >= s.size()) begin cut = 1'b1; break; end
        if (s[i][8]) begin res_q.push_back(R_FE); i++; cut = 1'b1; break; end
        exp_q.push_back({k == len - 1, s[i][7:0]});
        sum = sum + s[i][7:0];
        i++;
      end
      if (cut || i >= s.size()) continue;
      if (s[i][8]) res_q.push_back(R_FE);
      else if (8'(sum + s[i][7:0]) == 8'd0) res_q.push_back(R_DONE);
      else res_q.push_back(R_CSUM);
      i++;
    end
  endtask

  // ---------------- monitor / compare ----------------
  logic       p_rst = 1'b1, p_valid = 1'b0, p_ready = 1'b0, p_clr = 1'b0, p_rdrf = 1'b0;
  logic [8:0] p_out = '0;
  logic [8:0] mon_e;
  logic [3:0] mon_r;

  always @(negedge clk) begin
    if (!p_rst) begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_last, out_data}), 32'(p_out));
      end
      if (rdrf_clr) begin
        clr_pulses++;
        chk("consume_legal", 32'({p_rdrf, p_clr, p_valid & ~p_ready}), 32'b100);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_unexpected: actual=0x%0h required=no byte", {out_last, out_data});
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_byte", 32'({out_last, out_data}), 32'(mon_e));
        end
      end
      if (pkt_done || pkt_err) begin
        if (pkt_done) done_pulses++;
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL pkt_unexpected: actual=0x%0h required=no pulse", {pkt_done, pkt_err, err_code});
        end else begin
          mon_r = res_q.pop_front();
          chk("pkt_result", 32'({pkt_done, pkt_err, err_code}), 32'(mon_r));
        end
      end
    end
    p_rst   <= clr;
    p_valid <= out_valid;
    p_ready <= out_ready;
    p_clr   <= rdrf_clr;
    p_rdrf  <= rdrf;
    p_out   <= {out_last, out_data};
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Emulated uart_rx: rdrf stays up until the controller pulses rdrf_clr.
  task automatic wait_consume();
    int n = 0;
    do begin step(); n++; end while (!rdrf_clr && n < 300);
    chk("consume_seen", 32'(rdrf_clr), 32'd1);
    rdrf = 1'b0;
  endtask

  task automatic send_byte(input logic [8:0] v);
    rx_data = v[7:0];
    fe      = v[8];
    rdrf    = 1'b1;
    wait_consume();
  endtask

  task automatic send_all(input logic [8:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() + res_q.size()) != 0 && n < 400) begin step(); n++; end
    chk(name, 32'(exp_q.size() + res_q.size()), 32'd0);
    exp_q.delete();
    res_q.delete();
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] s[$];
  int c0, d0, n;

  initial begin
    // Reset
    clr = 1'b1;
    step(); step();
    chk_zero("reset_outputs");
    chk("reset_state", 32'(dbg_state), 32'(ST_HUNT));
    clr = 1'b0;
    step();

    // Good frame; checksum byte makes LEN+payload+CSUM == 0 mod 256
    s = '{9'h0A5, 9'h003, 9'h011, 9'h022, 9'h033, 9'h097};
    model_stream(s);
    chk("model_n_bytes", 32'(exp_q.size()), 32'd3);
    chk("model_first_byte", 32'(exp_q[0]), 32'h011);
    chk("model_last_byte", 32'(exp_q[2]), 32'h133);
    chk("model_good_res", 32'(res_q[0]), 32'(R_DONE));
    c0 = clr_pulses; d0 = done_pulses;
    send_all(s);
    wait_drain("good_drain");
    chk("good_rdrf_clr_pulses", 32'(clr_pulses - c0), 32'd6);
    chk("good_pkt_done_count", 32'(done_pulses - d0), 32'd1);
    chk("good_idle_busy", 32'(busy), 32'd0);

    // Bad checksum then a normal frame
    s = '{9'h0A5, 9'h002, 9'h001, 9'h002, 9'h000, 9'h0A5, 9'h001, 9'h040, 9'h0BF};
    model_stream(s);
    chk("model_badcs_res", 32'(res_q[0]), 32'(R_CSUM));
    chk("model_recover_res", 32'(res_q[1]), 32'(R_DONE));
    send_all(s);
    wait_drain("badcs_drain");

    // Noise in HUNT, LEN=0, LEN=17, LEN=16 (largest legal)
    s = '{9'h055, 9'h066, 9'h0A5, 9'h000, 9'h0A5, 9'h011, 9'h0A5, 9'h010};
    for (int k = 1; k <= 16; k++) s.push_back(9'(k));
    s.push_back(9'h068);
    model_stream(s);
    chk("model_len0_res", 32'(res_q[0]), 32'(R_LEN));
    chk("model_len17_res", 32'(res_q[1]), 32'(R_LEN));
    chk("model_len16_res", 32'(res_q[2]), 32'(R_DONE));
    chk("model_len16_bytes", 32'(exp_q.size()), 32'd16);
    c0 = clr_pulses;
    send_all(s);
    wait_drain("len_drain");
    chk("len_rdrf_clr_pulses", 32'(clr_pulses - c0), 32'd25);

    // Framing errors: in HUNT (ignored), 2nd payload, LEN, CSUM; then good frame
    s = '{9'h1A5, 9'h0A5, 9'h003, 9'h010, 9'h120, 9'h0A5, 9'h102,
          9'h0A5, 9'h001, 9'h033, 9'h1CC, 9'h0A5, 9'h001, 9'h033, 9'h0CC};
    model_stream(s);
    chk("model_fe_res", 32'(res_q[0]), 32'(R_FE));
    chk("model_fe_nres", 32'(res_q.size()), 32'd4);
    send_all(s);
    wait_drain("fe_drain");
    chk("fe_idle_busy", 32'(busy), 32'd0);

    // Backpressure: the second payload byte must wait for the first to be taken
    s = '{9'h0A5, 9'h002, 9'h05A, 9'h0C3, 9'h0E1};
    model_stream(s);
    out_ready = 1'b0;
    c0 = clr_pulses;
    fork
      send_all(s);
      begin
        repeat (50) step();
        chk("bp_rdrf_clr_pulses", 32'(clr_pulses - c0), 32'd3);
        chk("bp_out_held", 32'({out_valid, out_last, out_data}), 32'h25A);
        out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");

    // Inter-byte gap inside a frame
    s = '{9'h0A5, 9'h004, 9'h001};
    model_stream(s);
    send_all(s);
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
    res_q.push_back(R_TMO);
    n = 0;
    while (!pkt_err && n < 300) begin step(); n++; end
    chk("timeout_latency", 32'(n), 32'(TMO));
    wait_drain("timeout_drain");
    chk("timeout_idle_busy", 32'(busy), 32'd0);
    s = '{9'h0A5, 9'h003, 9'h077};
    model_stream(s);
    send_all(s);
`else
    repeat (150) step();
    chk("no_timeout_busy", 32'(busy), 32'd1);
`endif
    wait_drain("gap_drain");

    // Reset mid-DATA with a byte held pending through reset
    chk("mid_data_busy", 32'(busy), 32'd1);
    rx_data = SOF; fe = 1'b0; rdrf = 1'b1; clr = 1'b1;
    step();
    chk_zero("clr_outputs");
    step();
    chk_zero("clr_held_outputs");
    clr = 1'b0;
    exp_q.delete(); res_q.delete();
    s = '{9'h0A5, 9'h002, 9'h0AB, 9'h0CD, 9'h086};
    model_stream(s);
    c0 = clr_pulses; d0 = done_pulses;
    wait_consume();
    s.pop_front();
    send_all(s);
    wait_drain("post_clr_drain");
    chk("post_clr_rdrf_clr_pulses", 32'(clr_pulses - c0), 32'd5);
    chk("post_clr_pkt_done", 32'(done_pulses - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
